divider: RTL and testbench

Multi-cycle RV64M integer divider: computes quotient and remainder for DIV/DIVU/REM/REMU and the word forms DIVW/DIVUW/REMW/REMUW. It sits in the execute stage beside the single-cycle ALU. It takes operands from issue over a valid/ready handshake, iterates one quotient bit per cycle, and returns both results to writeback over a second valid/ready handshake. The caller selects quotient or remainder.

---
 rtl/divider.sv | 140 ++++++++++++++
 tb/tb_divider.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// Multi-cycle RV64M integer divider (DIV/DIVU/REM/REMU and the W forms).
// Restoring radix-2 division, one quotient bit per cycle. Operands come in
// over a valid/ready handshake and results leave over a second one.
module divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_valid,
    output logic        div_ready,
    input  logic        div_signed,
    input  logic        div_word,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] quotient,
    output logic [63:0] remainder
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state, state_next;
    logic [6:0]  count;

    // Iteration state: partial remainder, dividend/quotient shift register,
    // divisor magnitude and the sign/width flags latched at accept.
    logic [64:0] part_rem;
    logic [63:0] dq_shift;
    logic [63:0] dvs_mag;
    logic        q_neg, r_neg, is_word;

    logic [63:0] a_ext, b_ext, a_mag, b_mag;
    logic        a_neg, b_neg, div_zero, overflow, special, accept;
    logic [64:0] shifted, trial;
    logic        q_bit;
    logic [63:0] q_fix, r_fix;

    // Operand extension, magnitudes and special-case detection at accept.
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        if (div_word) begin
            a_ext = div_signed ? {{32{dividend[31]}}, dividend[31:0]} : {32'b0, dividend[31:0]};
            b_ext = div_signed ? {{32{divisor[31]}},  divisor[31:0]}  : {32'b0, divisor[31:0]};
        end else begin
            a_ext = dividend;
            b_ext = divisor;
        end
        a_neg    = div_signed & a_ext[63];
        b_neg    = div_signed & b_ext[63];
        a_mag    = a_neg ? (64'd0 - a_ext) : a_ext;
        b_mag    = b_neg ? (64'd0 - b_ext) : b_ext;
        div_zero = (b_ext == 64'd0);
        overflow = div_signed && (b_ext == {64{1'b1}}) &&
                   (a_ext == (div_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        special  = div_zero | overflow;
        accept   = div_valid && (state == IDLE) && !flush;
    end

    // One restoring step plus the sign fix-up applied in FIX.
    always_comb begin
        shifted = {part_rem[63:0], dq_shift[63]};
        trial   = shifted - {1'b0, dvs_mag};
        q_bit   = ~trial[64];
        q_fix   = q_neg ? (64'd0 - dq_shift) : dq_shift;
        r_fix   = r_neg ? (64'd0 - part_rem[63:0]) : part_rem[63:0];
        if (is_word) begin
            q_fix = {{32{q_fix[31]}}, q_fix[31:0]};
            r_fix = {{32{r_fix[31]}}, r_fix[31:0]};
        end
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept)           state_next = special ? DONE : CALC;
            CALC: if (count == 7'd1)    state_next = FIX;
            FIX:                        state_next = DONE;
            DONE: if (out_ready)        state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        div_ready = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Iteration counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= 7'd0;
            quotient  <= 64'd0;
            remainder <= 64'd0;
        end else begin
            if (accept) begin
                count <= div_word ? 7'd32 : 7'd64;
                if (div_zero) begin
                    quotient  <= {64{1'b1}};
                    remainder <= a_ext;
                end else if (overflow) begin
                    quotient  <= a_ext;
                    remainder <= 64'd0;
                end
            end else if (state == CALC) begin
                count <= count - 7'd1;
            end else if (state == FIX && !flush) begin
                quotient  <= q_fix;
                remainder <= r_fix;
            end
        end
    end

    // Datapath capture and shift; word dividends are left-aligned so the
    // MSB-first walk covers only their 32 bits.
    // NOTE: these registers are always loaded at accept before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            part_rem <= 65'd0;
            dq_shift <= div_word ? {a_mag[31:0], 32'd0} : a_mag;
            dvs_mag  <= b_mag;
            q_neg    <= a_neg ^ b_neg;
            r_neg    <= a_neg;
            is_word  <= div_word;
        end else if (state == CALC) begin
            part_rem <= q_bit ? trial : shifted;
            dq_shift <= {dq_shift[62:0], q_bit};
        end
    end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: a reference model computes expected
// quotient/remainder/latency, pushes them to a scoreboard queue when a
// request is driven, and pops them when out_valid appears.
module tb_divider;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, div_valid, div_ready, div_signed, div_word, flush;
    logic        out_valid, out_ready;
    logic [63:0] dividend, divisor, quotient, remainder;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    divider dut (
        .clk        (clk),
        .rst        (rst),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .div_signed (div_signed),
        .div_word   (div_word),
        .dividend   (dividend),
        .divisor    (divisor),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Reference model built on the simulator's own division operators.
    function automatic exp_t ref_div(input bit s, input bit w, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        logic [63:0] ea, eb;
        logic signed [31:0] sa32, sb32, sq32, sr32;
        logic [31:0] uq32, ur32;
        logic signed [63:0] sa64, sb64;
        ea = w ? (s ? {{32{a[31]}}, a[31:0]} : {32'b0, a[31:0]}) : a;
        eb = w ? (s ? {{32{b[31]}}, b[31:0]} : {32'b0, b[31:0]}) : b;
        e.lat = w ? 34 : 66;
        if (eb == 64'd0) begin
            e.q = {64{1'b1}}; e.r = ea; e.lat = 1;
        end else if (s && eb == {64{1'b1}} &&
                     ea == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) begin
            e.q = ea; e.r = 64'd0; e.lat = 1;
        end else if (w && s) begin
            sa32 = a[31:0]; sb32 = b[31:0];
            sq32 = sa32 / sb32; sr32 = sa32 % sb32;
            e.q = {{32{sq32[31]}}, sq32}; e.r = {{32{sr32[31]}}, sr32};
        end else if (w) begin
            uq32 = a[31:0] / b[31:0]; ur32 = a[31:0] % b[31:0];
            e.q = {{32{uq32[31]}}, uq32}; e.r = {{32{ur32[31]}}, ur32};
        end else if (s) begin
            sa64 = a; sb64 = b;
            e.q = sa64 / sb64; e.r = sa64 % sb64;
        end else begin
            e.q = a / b; e.r = a % b;
        end
        return e;
    endfunction

    // Drive one request, wait for its result, optionally stall the consumer.
    task automatic run_op(input bit s, input bit w, input logic [63:0] a, input logic [63:0] b,
                          input int hold, input string tag);
        exp_t e;
        int   lat;
        bit   busy_bad;
        bit   hold_bad;
        @(negedge clk);
        div_valid = 1'b1; div_signed = s; div_word = w; dividend = a; divisor = b;
        exp_q.push_back(ref_div(s, w, a, b));
        @(posedge clk);
        @(negedge clk);
        div_valid = 1'b0;
        dividend  = {$urandom, $urandom};
        divisor   = {$urandom, $urandom};
        lat = 1; busy_bad = 1'b0;
        while (!out_valid && lat < 200) begin
            if (div_ready) busy_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_busy"}, busy_bad | div_ready, 1'b0);
        if (exp_q.size() == 0) begin
            check({tag, "_scoreboard"}, 64'd0, 64'd1);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_lat"}, 64'(lat), 64'(e.lat));
        check({tag, "_q"}, quotient, e.q);
        check({tag, "_r"}, remainder, e.r);
        hold_bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!out_valid || div_ready || quotient !== e.q || remainder !== e.r) hold_bad = 1'b1;
        end
        if (hold > 0) check({tag, "_hold"}, hold_bad, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_drain"}, {out_valid, div_ready}, 2'b01);
    endtask

    // Start a long op, then abort it in CALC cycle 20 with flush or reset.
    task automatic abort_op(input bit use_rst, input string tag);
        bit rose;
        @(negedge clk);
        div_valid = 1'b1; div_signed = 1'b0; div_word = 1'b0;
        dividend = 64'hFFFF_0000_1234_5678; divisor = 64'd12345;
        @(posedge clk);
        @(negedge clk);
        div_valid = 1'b0;
        repeat (19) @(negedge clk);
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        @(negedge clk);
        rst = 1'b0; flush = 1'b0;
        check({tag, "_ready"}, div_ready, 1'b1);
        check({tag, "_valid"}, out_valid, 1'b0);
        if (use_rst) check({tag, "_qr"}, {quotient, remainder}, 128'd0);
        rose = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) rose = 1'b1;
        end
        check({tag, "_norise"}, rose, 1'b0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; div_valid = 1'b0; out_ready = 1'b0;
        div_signed = 1'b0; div_word = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_state", {div_ready, out_valid}, 2'b10);
        check("reset_q", quotient, 64'd0);
        check("reset_r", remainder, 64'd0);

        run_op(0, 0, 64'd100, 64'd7, 0, "divu_100_7");
        check("divu_100_7_const", {quotient, remainder}, {64'd14, 64'd2});
        run_op(1, 0, -64'sd7, 64'd2, 0, "div_m7_2");
        check("div_m7_2_const", {quotient, remainder},
              {64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF});
        run_op(0, 0, 64'd5, 64'd0, 0, "divu_by0");
        run_op(1, 1, 64'h0000_0001_8000_0000, 64'd0, 0, "divw_by0");
        check("divw_by0_const", remainder, 64'hFFFF_FFFF_8000_0000);
        run_op(1, 0, 64'h8000_0000_0000_0000, {64{1'b1}}, 0, "div_ovf");
        check("div_ovf_const", quotient, 64'h8000_0000_0000_0000);
        run_op(1, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0, "divw_ovf");
        check("divw_ovf_const", quotient, 64'hFFFF_FFFF_8000_0000);
        run_op(0, 1, 64'hDEAD_BEEF_FFFF_FFFF, 64'h1234_5678_0000_0001, 0, "divuw_garbage");
        check("divuw_garbage_const", {quotient, remainder}, {{64{1'b1}}, 64'd0});
        run_op(1, 1, 64'hABCD_0000_FFFF_FFF9, 64'h0000_0000_0000_0002, 0, "remw_m7_2");
        run_op(0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 10, "backpressure");

        for (int i = 0; i < 8; i++) begin
            logic [63:0] a, b;
            a = {$urandom, $urandom};
            b = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) b = -64'sd1;
            run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, b,
                   $urandom_range(0, 3), $sformatf("rand%0d", i));
        end

        abort_op(0, "flush");
        run_op(0, 0, 64'd9, 64'd3, 0, "after_flush");
        abort_op(1, "reset");
        run_op(0, 0, 64'd9, 64'd3, 0, "after_reset");
        check("after_reset_const", {quotient, remainder}, {64'd3, 64'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
